// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter (LSB first) fed by a small byte FIFO.
// Queued bytes go out back-to-back at DIV_CNT+1 clocks per bit.
`ifndef UartDivCnt
`define UartDivCnt 3
`endif

module uart_tx_fifo #(
  parameter int DIV_CNT    = `UartDivCnt,
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_end,
  output logic       tx
);

  localparam int DW = (DIV_CNT < 1) ? 1 : $clog2(DIV_CNT + 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(DIV_CNT);
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t state, state_next;

  logic [7:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               push, pop;
  logic               fifo_has_data;

  logic [7:0]    shift_reg;
  logic [2:0]    bit_cnt;
  logic [DW-1:0] div_cnt;
  logic          bit_tick;

  logic tx_next, end_next, load_shift, shift_en, bit_clr, bit_inc;

  assign fifo_has_data = (count != '0);
  assign tx_ready      = (count != FULL_CNT);
  assign tx_busy       = (state != IDLE) || fifo_has_data;
  assign push          = tx_start && tx_ready;
  assign bit_tick      = (div_cnt == DIV_MAX);

  // Storage needs no reset: pointers and count decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (FIFO_AW + 1)'(1);
        2'b01:   count <= count - (FIFO_AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (fifo_has_data) state_next = START;
      START: if (bit_tick) state_next = DATA;
      DATA:  if (bit_tick && bit_cnt == 3'd7) state_next = STOP;
      STOP:  if (bit_tick) state_next = fifo_has_data ? START : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A pop from STOP chains straight into the next start bit with no idle gap.
  always_comb begin
    pop        = 1'b0;
    tx_next    = tx;
    end_next   = 1'b0;
    load_shift = 1'b0;
    shift_en   = 1'b0;
    bit_clr    = 1'b0;
    bit_inc    = 1'b0;
    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (fifo_has_data) begin
          pop        = 1'b1;
          load_shift = 1'b1;
          tx_next    = 1'b0;
        end
      end
      START: begin
        if (bit_tick) begin
          tx_next = shift_reg[0];
          bit_clr = 1'b1;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_cnt == 3'd7) begin
            tx_next = 1'b1;
          end else begin
            tx_next  = shift_reg[1];
            shift_en = 1'b1;
            bit_inc  = 1'b1;
          end
        end
      end
      STOP: begin
        if (bit_tick) begin
          end_next = 1'b1;
          if (fifo_has_data) begin
            pop        = 1'b1;
            load_shift = 1'b1;
            tx_next    = 1'b0;
          end
        end
      end
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx        <= 1'b1;
      tx_end    <= 1'b0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
    end else begin
      tx     <= tx_next;
      tx_end <= end_next;
      if (load_shift)    shift_reg <= mem[rd_ptr];
      else if (shift_en) shift_reg <= {1'b0, shift_reg[7:1]};
      if (bit_clr)       bit_cnt <= '0;
      else if (bit_inc)  bit_cnt <= bit_cnt + 3'd1;
      if (state == IDLE || bit_tick) div_cnt <= '0;
      else                           div_cnt <= div_cnt + DW'(1);
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a frame-level model predicts every output each cycle,
// and a line decoder rebuilds transmitted bytes against the accepted-byte order.
module tb_uart_tx_fifo;

  localparam int DIV   = 3;
  localparam int DEPTH = 4;
  localparam int B     = DIV + 1;
  localparam int FRAME = 10 * B;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_ready, tx_busy, tx_end, tx;

  int total = 0;
  int bad   = 0;

  logic [7:0] mq[$];
  logic [7:0] rx_exp[$];
  logic [7:0] cur     = 8'h00;
  bit         active  = 1'b0;
  int         pos     = 0;
  logic       exp_tx  = 1'b1;
  logic       exp_end = 1'b0;
  bit         push_ok, end_now;

  int         end_seen  = 0;
  int         busy_seen = 0;
  int         rx_seen   = 0;
  int         rx_phase  = -1;
  logic [7:0] rx_byte   = 8'h00;
  logic [7:0] last_rx   = 8'h00;

  int         e0, b0, r0, e1, r1, pushed;
  logic [9:0] pat1;

  uart_tx_fifo #(.DIV_CNT(DIV), .FIFO_DEPTH(DEPTH), .FIFO_AW(2)) dut (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_end(tx_end), .tx(tx)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic [7:0] data);
    @(posedge clk);
    #1;
    tx_start = start;
    tx_data  = data;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'($urandom));
  endtask

  task automatic waitIdle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx_busy === 1'b0) break;
    end
    checkOutput("idle_reached", tx_busy, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  // Line level at a given clock offset within a frame: start, 8 data LSB first, stop.
  function automatic logic frame_bit(input logic [7:0] b, input int p);
    int idx;
    idx = p / B;
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (rst_n === 1'b0) begin
      mq.delete();
      rx_exp.delete();
      active  = 1'b0;
      pos     = 0;
      exp_tx  = 1'b1;
      exp_end = 1'b0;
    end else begin
      push_ok = (tx_start === 1'b1) && (mq.size() < DEPTH);
      end_now = active && (pos == FRAME - 1);
      exp_end = end_now;
      if ((!active || end_now) && mq.size() != 0) begin
        cur = mq.pop_front();
        rx_exp.push_back(cur);
        active = 1'b1;
        pos    = 0;
      end else if (end_now) begin
        active = 1'b0;
      end else if (active) begin
        pos++;
      end
      if (push_ok) mq.push_back(tx_data);
      exp_tx = active ? frame_bit(cur, pos) : 1'b1;
    end
  end

  initial forever begin
    @(negedge clk);
    checkOutput("tx", tx, exp_tx);
    checkOutput("tx_end", tx_end, exp_end);
    checkOutput("tx_ready", tx_ready, mq.size() != DEPTH);
    checkOutput("tx_busy", tx_busy, active || mq.size() != 0);
    if (tx_end === 1'b1) end_seen++;
    if (tx_busy === 1'b1) busy_seen++;
    if (rst_n === 1'b0) begin
      rx_phase = -1;
    end else if (rx_phase < 0) begin
      if (tx === 1'b0) rx_phase = 0;
    end else begin
      rx_phase++;
      if ((rx_phase % B) == (B / 2) && rx_phase >= B && rx_phase < 9 * B)
        rx_byte[rx_phase / B - 1] = tx;
      if (rx_phase == 9 * B + B / 2) begin
        checkOutput("rx_stop_bit", tx, 1'b1);
        if (rx_exp.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL rx_frame: got %0h want no frame", rx_byte);
        end else begin
          checkOutput("rx_byte", rx_byte, rx_exp.pop_front());
        end
        last_rx = rx_byte;
        rx_seen++;
        rx_phase = -1;
      end
    end
  end

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("rst_tx", tx, 1'b1);
    checkOutput("rst_ready", tx_ready, 1'b1);
    checkOutput("rst_busy", tx_busy, 1'b0);
    checkOutput("rst_end", tx_end, 1'b0);

    // single 0x55 frame, checked bit by bit against the literal line pattern
    e0 = end_seen; b0 = busy_seen; r0 = rx_seen;
    pat1 = 10'b1010101010;
    applyStimulus(1'b1, 8'h55);
    applyStimulus(1'b0, 8'hAA);
    @(posedge clk);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      checkOutput("t1_line", tx, pat1[i / B]);
    end
    @(negedge clk);
    checkOutput("t1_end_pulse", tx_end, 1'b1);
    checkOutput("t1_busy_after", tx_busy, 1'b0);
    @(negedge clk);
    checkOutput("t1_end_drop", tx_end, 1'b0);
    checkOutput("t1_end_count", end_seen - e0, 1);
    checkOutput("t1_busy_cycles", busy_seen - b0, 41);
    checkOutput("t1_rx_byte", last_rx, 8'h55);

    // four consecutive pushes, back-to-back frames
    e0 = end_seen; b0 = busy_seen; r0 = rx_seen;
    applyStimulus(1'b1, 8'hA3);
    applyStimulus(1'b1, 8'h0F);
    applyStimulus(1'b1, 8'hFF);
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b0, 8'h5A);
    waitIdle(400);
    checkOutput("t2_end_count", end_seen - e0, 4);
    checkOutput("t2_busy_cycles", busy_seen - b0, 161);
    checkOutput("t2_rx_count", rx_seen - r0, 4);
    checkOutput("t2_last_byte", last_rx, 8'h00);

    // tx_start held for six bytes: the sixth arrives while full and is dropped
    e0 = end_seen; b0 = busy_seen; r0 = rx_seen;
    applyStimulus(1'b1, 8'h11);
    applyStimulus(1'b1, 8'h22);
    applyStimulus(1'b1, 8'h33);
    applyStimulus(1'b1, 8'h44);
    applyStimulus(1'b1, 8'h55);
    applyStimulus(1'b1, 8'h66);
    @(negedge clk);
    checkOutput("t3_ready_full", tx_ready, 1'b0);
    applyStimulus(1'b0, 8'h00);
    waitIdle(500);
    checkOutput("t3_end_count", end_seen - e0, 5);
    checkOutput("t3_busy_cycles", busy_seen - b0, 201);
    checkOutput("t3_last_byte", last_rx, 8'h55);

    // pushes landing on STOP-state pops, with pointers wrapping
    e0 = end_seen; r0 = rx_seen;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h81 + i));
    idleCycles(36);
    applyStimulus(1'b1, 8'hC1);
    checkOutput("t4_ready_full_pop", tx_ready, 1'b0);
    idleCycles(39);
    applyStimulus(1'b1, 8'hC2);
    checkOutput("t4_ready_second_pop", tx_ready, 1'b1);
    applyStimulus(1'b0, 8'h00);
    waitIdle(600);
    checkOutput("t4_end_count", end_seen - e0, 6);
    checkOutput("t4_rx_count", rx_seen - r0, 6);
    checkOutput("t4_last_byte", last_rx, 8'hC2);

    // reset in the middle of the data bits of 0x00 with another byte queued
    e0 = end_seen;
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b1, 8'h7E);
    idleCycles(14);
    @(posedge clk);
    #1;
    checkOutput("t5_tx_mid_data", tx, 1'b0);
    checkOutput("t5_busy_mid", tx_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_tx", tx, 1'b1);
    checkOutput("t5_rst_ready", tx_ready, 1'b1);
    checkOutput("t5_rst_busy", tx_busy, 1'b0);
    checkOutput("t5_rst_end", tx_end, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    e1 = end_seen; r1 = rx_seen;
    checkOutput("t5_no_end_aborted", e1 - e0, 0);
    applyStimulus(1'b1, 8'h3C);
    applyStimulus(1'b0, 8'h00);
    waitIdle(200);
    checkOutput("t5_end_count", end_seen - e1, 1);
    checkOutput("t5_rx_count", rx_seen - r1, 1);
    checkOutput("t5_last_byte", last_rx, 8'h3C);

    // 256 random bytes pushed whenever the FIFO has room
    e0 = end_seen; r0 = rx_seen;
    pushed = 0;
    for (int c = 0; c < 15000 && pushed < 256; c++) begin
      @(posedge clk);
      #1;
      if (tx_ready === 1'b1) begin
        tx_start = 1'b1;
        tx_data  = 8'($urandom);
        pushed++;
      end else begin
        tx_start = 1'b0;
      end
    end
    checkOutput("t6_all_pushed", pushed, 256);
    applyStimulus(1'b0, 8'h00);
    waitIdle(1000);
    checkOutput("t6_end_count", end_seen - e0, 256);
    checkOutput("t6_rx_count", rx_seen - r0, 256);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
